seven_segment_chaser: RTL and testbench

- Parametrised segment-animation engine for a single 7-segment digit.
- Successor to the fixed one-hot segment loop. Adds:
  - configurable ring length
  - an internal programmable prescaler
  - enable/freeze
  - direction control
  - four animation modes: CHASE, BOUNCE, FILL, BLINK
- Sits between the board clock and the display pins; no external counter required.

---
 rtl/seven_segment_chaser.sv | 119 +++++++++++
 tb/tb_seven_segment_chaser.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_chaser.sv
// Segment-animation engine for one 7-segment digit: CHASE, BOUNCE, FILL and BLINK
// over a configurable ring, stepped by an internal programmable prescaler.
module seven_segment_chaser #(
  parameter int N_SEG      = 6,
  parameter int DIV_W      = 24,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int POS_W     = $clog2(N_SEG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] div_limit,
  output logic [6:0]       pinoutdisplay7segment,
  output logic [POS_W-1:0] pos,
  output logic             step
);

  typedef enum logic [1:0] {
    CHASE  = 2'b00,
    BOUNCE = 2'b01,
    FILL   = 2'b10,
    BLINK  = 2'b11
  } mode_t;

  logic [DIV_W-1:0] presc;
  logic             up;
  logic             phase;
  mode_t            mode_q;
  logic             dir_q;

  logic             tick;
  logic [POS_W-1:0] pos_nx;
  logic             up_nx;
  logic             phase_nx;
  logic [6:0]       seg;

  // A limit lowered below the running count never fires early: the count
  // runs on to all-ones, ticks there and wraps to zero.
  assign tick = en && ((presc == div_limit) || (presc == '1));

  always_comb begin
    pos_nx   = pos;
    up_nx    = up;
    phase_nx = phase;
    unique case (mode_q)
      CHASE: begin
        if (dir) begin
          pos_nx = (pos == '0) ? POS_W'(N_SEG - 1) : pos - POS_W'(1);
        end else begin
          pos_nx = (pos == POS_W'(N_SEG - 1)) ? '0 : pos + POS_W'(1);
        end
      end
      BOUNCE: begin
        if (up) begin
          pos_nx = pos + POS_W'(1);
          if (pos_nx == POS_W'(N_SEG - 1)) up_nx = 1'b0;
        end else begin
          pos_nx = pos - POS_W'(1);
          if (pos_nx == '0) up_nx = 1'b1;
        end
      end
      FILL: begin
        pos_nx = (pos == POS_W'(N_SEG)) ? '0 : pos + POS_W'(1);
      end
      BLINK: begin
        phase_nx = ~phase;
        pos_nx   = {{(POS_W-1){1'b0}}, ~phase};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      pos    <= '0;
      up     <= 1'b1;
      phase  <= 1'b0;
      step   <= 1'b0;
      mode_q <= mode_t'(mode);
      dir_q  <= dir;
    end else if (mode_t'(mode) != mode_q) begin
      // A mode change restarts the animation and swallows any coincident tick.
      mode_q <= mode_t'(mode);
      presc  <= '0;
      pos    <= '0;
      up     <= 1'b1;
      phase  <= 1'b0;
      step   <= 1'b0;
    end else begin
      step <= 1'b0;
      if (tick) begin
        presc <= '0;
        pos   <= pos_nx;
        up    <= up_nx;
        phase <= phase_nx;
        dir_q <= dir;
        step  <= 1'b1;
      end else if (en) begin
        presc <= presc + DIV_W'(1);
      end
    end
  end

  always_comb begin
    seg = '0;
    for (int unsigned i = 0; i < N_SEG; i++) begin
      unique case (mode_q)
        CHASE, BOUNCE: seg[i] = (pos == POS_W'(i));
        FILL:          seg[i] = dir_q ? ((i + 32'(pos)) >= 32'(N_SEG)) : (i < 32'(pos));
        BLINK:         seg[i] = phase;
      endcase
    end
  end

  assign pinoutdisplay7segment = ACTIVE_LOW ? ~seg : seg;

endmodule

// File: tb/tb_seven_segment_chaser.sv
// Bench for seven_segment_chaser: two instances (6-segment active-high, 7-segment
// active-low) driven in lockstep and compared each cycle against an abstract model.
module tb_seven_segment_chaser;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        dir;
  logic [23:0] div_limit;

  logic [6:0] seg6, seg7;
  logic [2:0] pos6, pos7;
  logic       step6, step7;

  int n_pass  = 0;
  int n_total = 0;
  bit checking = 1'b0;

  // Abstract model: step count k since mode start, plus a chase position.
  int m_cnt[2];
  int m_k[2];
  int m_cp[2];
  int m_mode[2];
  bit m_dq[2];
  bit m_step[2];

  int bounce_exp[11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
  int fill_up_exp[7] = '{1, 3, 7, 15, 31, 63, 0};
  int fill_dn_exp[3] = '{32, 48, 56};
  int blink_exp[4]   = '{'h00, 'h7f, 'h00, 'h7f};

  seven_segment_chaser #(.N_SEG(6), .DIV_W(24), .ACTIVE_LOW(1'b0)) dut6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .div_limit(div_limit),
    .pinoutdisplay7segment(seg6), .pos(pos6), .step(step6)
  );

  seven_segment_chaser #(.N_SEG(7), .DIV_W(24), .ACTIVE_LOW(1'b1)) dut7 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .div_limit(div_limit),
    .pinoutdisplay7segment(seg7), .pos(pos7), .step(step7)
  );

  always #5 clk = ~clk;

  function automatic int nseg(int d);
    return (d == 0) ? 6 : 7;
  endfunction

  function automatic int model_pos(int d);
    int n;
    int m;
    n = nseg(d);
    case (m_mode[d])
      0: return m_cp[d];
      1: begin
        m = m_k[d] % (2 * n - 2);
        return (m < n) ? m : (2 * n - 2 - m);
      end
      2: return m_k[d] % (n + 1);
      default: return m_k[d] % 2;
    endcase
  endfunction

  function automatic int model_seg(int d);
    int n;
    int p;
    int mask;
    n = nseg(d);
    p = model_pos(d);
    case (m_mode[d])
      0, 1: mask = 1 << p;
      2: mask = m_dq[d] ? (((1 << p) - 1) << (n - p)) : ((1 << p) - 1);
      default: mask = (p != 0) ? ((1 << n) - 1) : 0;
    endcase
    return (d == 1) ? (~mask & 'h7f) : mask;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_cnt[d] = 0; m_k[d] = 0; m_cp[d] = 0;
        m_mode[d] = int'(mode); m_dq[d] = dir; m_step[d] = 1'b0;
      end else if (int'(mode) != m_mode[d]) begin
        m_mode[d] = int'(mode);
        m_cnt[d] = 0; m_k[d] = 0; m_cp[d] = 0; m_step[d] = 1'b0;
      end else if (!en) begin
        m_step[d] = 1'b0;
      end else if (m_cnt[d] == int'(div_limit)) begin
        m_cnt[d] = 0;
        m_k[d]++;
        m_cp[d] = dir ? (m_cp[d] + nseg(d) - 1) % nseg(d) : (m_cp[d] + 1) % nseg(d);
        m_dq[d] = dir;
        m_step[d] = 1'b1;
      end else begin
        m_cnt[d]++;
        m_step[d] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("seg6", int'(seg6), model_seg(0));
      chk("pos6", int'(pos6), model_pos(0));
      chk("step6", int'(step6), int'(m_step[0]));
      chk("seg7", int'(seg7), model_seg(1));
      chk("pos7", int'(pos7), model_pos(1));
      chk("step7", int'(step7), int'(m_step[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; dir = 1'b0; div_limit = 24'd0;
    cyc(2);
    chk("rst_seg6", int'(seg6), 'h01);
    chk("rst_seg7", int'(seg7), 'h7e);
    chk("rst_step6", int'(step6), 0);
    checking = 1'b1;

    // CHASE, tick every cycle
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cyc(1);
      chk("chase_seg6", int'(seg6), 1 << (i % 6));
      chk("chase_step6", int'(step6), 1);
    end

    // CHASE with period 4, direction flip mid-step, freeze
    rst = 1'b1; div_limit = 24'd3;
    cyc(1);
    rst = 1'b0;
    cyc(4); chk("div_pos1", int'(pos6), 1);
    cyc(4); chk("div_pos2", int'(pos6), 2);
    cyc(2); chk("mid_pos2", int'(pos6), 2);
    dir = 1'b1;
    cyc(1); chk("dir_hold", int'(pos6), 2);
    cyc(1); chk("dir_pos1", int'(pos6), 1);
    cyc(1);
    en = 1'b0;
    cyc(10);
    chk("freeze_pos", int'(pos6), 1);
    chk("freeze_step", int'(step6), 0);
    en = 1'b1;
    cyc(2); chk("resume_hold", int'(pos6), 1);
    cyc(1); chk("resume_pos0", int'(pos6), 0);

    // BOUNCE
    mode = 2'b01; dir = 1'b0; div_limit = 24'd0;
    cyc(1);
    chk("bounce_start", int'(pos6), 0);
    chk("bounce_step0", int'(step6), 0);
    for (int i = 0; i < 11; i++) begin
      cyc(1);
      chk("bounce_pos6", int'(pos6), bounce_exp[i]);
    end

    // FILL ascending then descending
    mode = 2'b10;
    cyc(1);
    chk("fill_start", int'(seg6), 0);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      chk("fill_up_seg6", int'(seg6), fill_up_exp[i]);
    end
    dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("fill_dn_seg6", int'(seg6), fill_dn_exp[i]);
    end

    // BLINK on the active-low 7-segment ring, then switch to CHASE mid-count
    mode = 2'b11;
    cyc(1);
    chk("blink_start7", int'(seg7), 'h7f);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("blink_seg7", int'(seg7), blink_exp[i]);
    end
    div_limit = 24'd3;
    cyc(2);
    mode = 2'b00; dir = 1'b0;
    cyc(1);
    chk("sw_seg7", int'(seg7), 'h7e);
    chk("sw_pos7", int'(pos7), 0);
    chk("sw_step7", int'(step7), 0);
    cyc(3); chk("sw_hold7", int'(pos7), 0);
    cyc(1);
    chk("sw_tick7", int'(pos7), 1);
    chk("sw_tstep7", int'(step7), 1);

    // Reset mid-run and reset coincident with a tick
    div_limit = 24'd0;
    cyc(3); chk("pre_rst_pos6", int'(pos6), 4);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_pos6", int'(pos6), 0);
    chk("mid_rst_seg6", int'(seg6), 'h01);
    chk("mid_rst_step6", int'(step6), 0);
    rst = 1'b0;
    cyc(2); chk("post_rst_pos6", int'(pos6), 2);
    rst = 1'b1;
    cyc(1);
    chk("tick_rst_pos6", int'(pos6), 0);
    chk("tick_rst_step6", int'(step6), 0);
    rst = 1'b0;
    cyc(2);
    checking = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
